// File: rtl/mm_mem.sv
// mm_mem: matrix memory that answers the matrix-multiply engine's memory port.
//
// Holds a three-word dimension header (row1, col1, col2) and operands A and B.
// The engine reads them combinationally and writes 40-bit results, which are
// captured in row-major order. The host preloads operands, starts the engine
// with go and reads results back through a registered port.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   i, j                engine row/column address (i = word number for header)
//   read, write, index  engine strobes and operand select (0 = A, 1 = B)
//   write_data          engine result word
//   read_data           combinational response to the engine
//   eng_reset           registered active-high reset to the engine
//   ld_en/sel/addr/data host load port (sel 0 = header, 1 = A, 2 = B)
//   go, clr             host start pulse, synchronous return to EMPTY
//   rb_addr, rb_data    result readback (one cycle latency)
//   wr_count, done      results captured, job complete
//   err_code            0 none, 1 bad header, 2 result overflow, 3 bad read
module mm_mem #(
    parameter int DIM_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] i,
    input  logic [19:0] j,
    input  logic        read,
    input  logic        write,
    input  logic        index,
    input  logic [39:0] write_data,
    output logic [19:0] read_data,
    output logic        eng_reset,
    input  logic        ld_en,
    input  logic [1:0]  ld_sel,
    input  logic [11:0] ld_addr,
    input  logic [19:0] ld_data,
    input  logic        go,
    input  logic        clr,
    input  logic [11:0] rb_addr,
    output logic [39:0] rb_data,
    output logic [11:0] wr_count,
    output logic        done,
    output logic [1:0]  err_code
);

    localparam int DEPTH = DIM_MAX * DIM_MAX;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [19:0] DIM20   = 20'(DIM_MAX);
    localparam logic [11:0] DEPTH12 = 12'(DEPTH);

    typedef enum logic [2:0] {S_EMPTY, S_READY, S_RUN, S_DONE, S_ERR} state_t;

    state_t      state_q, state_d;
    logic [11:0] wr_count_q, wr_count_d;
    logic [1:0]  err_q, err_d;
    logic        eng_reset_q;
    logic [39:0] rb_data_q;
    logic [19:0] h_q [3];

    logic [19:0] a_mem [DEPTH];
    logic [19:0] b_mem [DEPTH];
    logic [39:0] r_mem [DEPTH];

    logic [19:0] row1, col1, col2;
    assign row1 = h_q[0];
    assign col1 = h_q[1];
    assign col2 = h_q[2];

    logic header_ok;
    assign header_ok = (row1 != 0) && (row1 <= DIM20) &&
                       (col1 != 0) && (col1 <= DIM20) &&
                       (col2 != 0) && (col2 <= DIM20);

    // Engine access decode; only meaningful while the engine is released.
    logic eng_active, hdr_rd, mat_rd, res_wr;
    assign eng_active = (state_q == S_READY) || (state_q == S_RUN) || (state_q == S_DONE);
    assign hdr_rd = eng_active && read && write;
    assign mat_rd = eng_active && read && !write;
    assign res_wr = eng_active && !read && write;

    // The DIM_MAX bound also protects the address if the header is reloaded
    // with a bad value while READY.
    logic a_in_range, b_in_range, mat_in_range;
    logic [AW-1:0] mat_addr;
    assign a_in_range   = (i < row1) && (j < col1) && (i < DIM20) && (j < DIM20);
    assign b_in_range   = (i < col1) && (j < col2) && (i < DIM20) && (j < DIM20);
    assign mat_in_range = index ? b_in_range : a_in_range;
    assign mat_addr     = AW'(i * DIM_MAX + j);

    always_comb begin
        read_data = '0;
        if (hdr_rd) begin
            if (i < 20'd3) read_data = h_q[i[1:0]];
        end else if (mat_rd && mat_in_range) begin
            read_data = index ? b_mem[mat_addr] : a_mem[mat_addr];
        end
    end

    logic [39:0] total;
    logic [11:0] wr_next;
    logic        wr_room, final_wr;
    assign total    = row1 * col2;
    assign wr_next  = wr_count_q + 12'd1;
    assign wr_room  = wr_count_q < DEPTH12;
    assign final_wr = ({28'd0, wr_next} == total);

    logic res_we;

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        err_d      = err_q;
        res_we     = 1'b0;
        if (clr) begin
            state_d    = S_EMPTY;
            wr_count_d = '0;
            err_d      = 2'd0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (go) begin
                        if (header_ok) begin
                            state_d = S_READY;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 2'd1;
                        end
                    end
                end
                S_READY, S_RUN: begin
                    if (state_q == S_READY && (read || write)) state_d = S_RUN;
                    if (res_wr && wr_room) begin
                        res_we     = 1'b1;
                        wr_count_d = wr_next;
                        if (final_wr) state_d = S_DONE;
                    end else if (state_q == S_RUN && mat_rd && !mat_in_range) begin
                        state_d = S_ERR;
                        err_d   = 2'd3;
                    end
                end
                S_DONE: begin
                    if (res_wr) begin
                        state_d = S_ERR;
                        err_d   = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_EMPTY;
            wr_count_q  <= '0;
            err_q       <= 2'd0;
            eng_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            err_q       <= err_d;
            eng_reset_q <= (state_d == S_EMPTY) || (state_d == S_ERR);
        end
    end

    // Host loads are only accepted before the engine starts running.
    logic ld_ok;
    assign ld_ok = ld_en && !clr && ((state_q == S_EMPTY) || (state_q == S_READY));

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hdr
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    h_q[gi] <= '0;
                end else if (ld_ok && ld_sel == 2'd0 && ld_addr == 12'(gi)) begin
                    h_q[gi] <= ld_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (ld_ok && ld_sel == 2'd1 && ld_addr < DEPTH12) a_mem[ld_addr[AW-1:0]] <= ld_data;
        if (ld_ok && ld_sel == 2'd2 && ld_addr < DEPTH12) b_mem[ld_addr[AW-1:0]] <= ld_data;
        if (res_we) r_mem[wr_count_q[AW-1:0]] <= write_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rb_data_q <= '0;
        end else if (rb_addr < DEPTH12) begin
            rb_data_q <= r_mem[rb_addr[AW-1:0]];
        end else begin
            rb_data_q <= '0;
        end
    end

    assign eng_reset = eng_reset_q;
    assign rb_data   = rb_data_q;
    assign wr_count  = wr_count_q;
    assign done      = (state_q == S_DONE);
    assign err_code  = err_q;

endmodule

// File: tb/tb_mm_mem.sv
module tb_mm_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] i, j;
    logic        read, write, index;
    logic [39:0] write_data;
    logic [19:0] read_data;
    logic        eng_reset;
    logic        ld_en;
    logic [1:0]  ld_sel;
    logic [11:0] ld_addr;
    logic [19:0] ld_data;
    logic        go, clr;
    logic [11:0] rb_addr;
    logic [39:0] rb_data;
    logic [11:0] wr_count;
    logic        done;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    mm_mem #(.DIM_MAX(8)) dut (
        .clk(clk), .reset(reset), .i(i), .j(j), .read(read), .write(write),
        .index(index), .write_data(write_data), .read_data(read_data),
        .eng_reset(eng_reset), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .go(go), .clr(clr), .rb_addr(rb_addr), .rb_data(rb_data),
        .wr_count(wr_count), .done(done), .err_code(err_code)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        idx;
        logic [19:0] ii;
        logic [19:0] jj;
        logic [39:0] wd;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[13];
    logic [39:0] exp_r[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input logic [11:0] addr, input logic [19:0] data);
        ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic load_hdr(input logic [19:0] r1, input logic [19:0] c1, input logic [19:0] c2);
        load(2'd0, 12'd0, r1);
        load(2'd0, 12'd1, c1);
        load(2'd0, 12'd2, c2);
    endtask

    task automatic pulse_go();
        go = 1'b1; tick(); go = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    // One engine cycle: drive strobes, check the combinational response, clock it.
    task automatic eng(input logic rd, input logic wr, input logic idx,
                       input logic [19:0] ii, input logic [19:0] jj,
                       input logic [39:0] wd, input logic [19:0] exp, input string name);
        read = rd; write = wr; index = idx; i = ii; j = jj; write_data = wd;
        #1;
        check(name, read_data, exp);
        $display("txn %s rd=%0d wr=%0d idx=%0d i=%0d j=%0d wd=%0h read_data=%0h",
                 name, rd, wr, idx, ii, jj, wd, read_data);
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        reset = 1'b0; i = '0; j = '0; read = 1'b0; write = 1'b0; index = 1'b0;
        write_data = '0; ld_en = 1'b0; ld_sel = '0; ld_addr = '0; ld_data = '0;
        go = 1'b0; clr = 1'b0; rb_addr = '0;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 20'd0, 20'd0, 40'd0, 20'd2};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 20'd1, 20'd0, 40'd0, 20'd3};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 20'd2, 20'd0, 40'd0, 20'd2};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 20'd3, 20'd0, 40'd0, 20'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 20'd0, 20'd0, 40'd0, 20'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 20'd1, 20'd2, 40'd0, 20'd6};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 20'd2, 20'd1, 40'd0, 20'd12};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 20'd0, 20'd1, 40'd0, 20'd8};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 20'd0, 20'd0, 40'd0, 20'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 20'd0, 20'd0, 40'd58,  20'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 20'd0, 20'd0, 40'd64,  20'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 20'd0, 20'd0, 40'd139, 20'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 20'd0, 20'd0, 40'd154, 20'd0};
        exp_r[0] = 40'd58; exp_r[1] = 40'd64; exp_r[2] = 40'd139; exp_r[3] = 40'd154;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_eng_reset", eng_reset, 1);
        check("rst_read_data", read_data, 0);
        check("rst_rb_data", rb_data, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_done", done, 0);
        check("rst_err_code", err_code, 0);
        reset = 1'b1;
        tick();

        // Job 1: 2x3 * 3x2
        load_hdr(20'd2, 20'd3, 20'd2);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                load(2'd1, 12'(r * 8 + c), 20'(r * 3 + c + 1));
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
                load(2'd2, 12'(r * 8 + c), 20'(7 + r * 2 + c));
        check("pre_go_eng_reset", eng_reset, 1);
        pulse_go();
        check("go_eng_reset", eng_reset, 0);
        for (int k = 0; k < 13; k++)
            eng(vecs[k].rd, vecs[k].wr, vecs[k].idx, vecs[k].ii, vecs[k].jj,
                vecs[k].wd, vecs[k].exp, $sformatf("job1_v%0d", k));
        check("job1_done", done, 1);
        check("job1_wr_count", wr_count, 4);
        check("job1_err", err_code, 0);
        check("job1_eng_reset", eng_reset, 0);
        for (int k = 0; k < 4; k++) begin
            rb_addr = 12'(k);
            tick();
            check($sformatf("job1_rb%0d", k), rb_data, exp_r[k]);
            $display("txn readback addr=%0d rb_data=%0d", k, rb_data);
        end

        // Extra write after DONE
        eng(1'b0, 1'b1, 1'b0, 20'd0, 20'd0, 40'd999, 20'd0, "extra_wr");
        check("ovf_err", err_code, 2);
        check("ovf_wr_count", wr_count, 4);
        check("ovf_done", done, 0);
        check("ovf_eng_reset", eng_reset, 1);
        eng(1'b1, 1'b1, 1'b0, 20'd0, 20'd0, 40'd0, 20'd0, "err_hdr_rd");

        // Bad header
        pulse_clr();
        check("clr_err", err_code, 0);
        check("clr_wr_count", wr_count, 0);
        load_hdr(20'd0, 20'd3, 20'd2);
        pulse_go();
        check("badhdr_err", err_code, 1);
        check("badhdr_eng_reset", eng_reset, 1);
        eng(1'b1, 1'b1, 1'b0, 20'd0, 20'd0, 40'd0, 20'd0, "badhdr_hdr_rd");
        eng(1'b1, 1'b0, 1'b0, 20'd0, 20'd0, 40'd0, 20'd0, "badhdr_mat_rd");

        // 1x1x1 signed job: -1 * 3
        pulse_clr();
        load_hdr(20'd1, 20'd1, 20'd1);
        load(2'd1, 12'd0, 20'hFFFFF);
        load(2'd2, 12'd0, 20'h00003);
        pulse_go();
        eng(1'b1, 1'b0, 1'b0, 20'd0, 20'd0, 40'd0, 20'hFFFFF, "one_a");
        eng(1'b1, 1'b0, 1'b1, 20'd0, 20'd0, 40'd0, 20'h00003, "one_b");
        eng(1'b0, 1'b1, 1'b0, 20'd0, 20'd0, 40'hFFFFFFFFFD, 20'd0, "one_wr");
        check("one_done", done, 1);
        rb_addr = 12'd0;
        tick();
        check("one_rb0", rb_data, 40'hFFFFFFFFFD);

        // Out-of-range B read in RUN
        pulse_clr();
        load_hdr(20'd2, 20'd3, 20'd2);
        pulse_go();
        eng(1'b1, 1'b1, 1'b0, 20'd0, 20'd0, 40'd0, 20'd2, "oor_hdr");
        eng(1'b1, 1'b0, 1'b1, 20'd3, 20'd0, 40'd0, 20'd0, "oor_b_rd");
        check("oor_err", err_code, 3);
        check("oor_eng_reset", eng_reset, 1);

        // clr mid-RUN, then header-only reload
        pulse_clr();
        load_hdr(20'd2, 20'd3, 20'd2);
        pulse_go();
        eng(1'b1, 1'b1, 1'b0, 20'd0, 20'd0, 40'd0, 20'd2, "clr_hdr");
        eng(1'b0, 1'b1, 1'b0, 20'd0, 20'd0, 40'd5, 20'd0, "clr_wr");
        check("clr_run_wr_count", wr_count, 1);
        pulse_clr();
        check("clr_run_wr_count0", wr_count, 0);
        check("clr_run_eng_reset", eng_reset, 1);
        check("clr_run_err", err_code, 0);
        load_hdr(20'd2, 20'd3, 20'd2);
        load(2'd1, 12'd64, 20'h12345);  // beyond storage: must not land anywhere
        pulse_go();
        // Same-cycle load of A(1,1) and read of A(1,1) in READY: old value
        ld_en = 1'b1; ld_sel = 2'd1; ld_addr = 12'd9; ld_data = 20'd77;
        eng(1'b1, 1'b0, 1'b0, 20'd1, 20'd1, 40'd0, 20'd5, "same_cycle_old");
        ld_en = 1'b0;
        eng(1'b1, 1'b0, 1'b0, 20'd1, 20'd1, 40'd0, 20'd77, "same_cycle_new");
        eng(1'b1, 1'b0, 1'b1, 20'd1, 20'd0, 40'd0, 20'd9, "keep_b10");
        eng(1'b1, 1'b0, 1'b0, 20'd0, 20'd0, 40'd0, 20'hFFFFF, "keep_a00");
        eng(1'b0, 1'b1, 1'b0, 20'd0, 20'd0, 40'd1, 20'd0, "pre_rst_wr");

        // Asynchronous reset mid-RUN
        #2;
        reset = 1'b0;
        #1;
        check("async_eng_reset", eng_reset, 1);
        check("async_wr_count", wr_count, 0);
        check("async_done", done, 0);
        #3;
        reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
